adc_sar_controller: RTL and testbench

Successive-approximation control logic for the 12-bit charge-redistribution SAR ADC. It sequences the sample phase and the 12 binary-search trials, and drives the 12-bit trial code to the row/column thermometer decoder of the capacitor array. It resolves each bit from the comparator and presents the final code with a one-cycle valid strobe. It is the code producer for the array decoder and sits between the digital host interface and the analog core.

---
 rtl/adc_sar_pkg.sv | 15 +
 rtl/adc_sar_if.sv | 24 ++
 rtl/adc_sar_osr_acc.sv | 35 +++
 rtl/adc_sar_controller.sv | 167 ++++++++++++++++
 tb/tb_adc_sar_controller.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_sar_pkg.sv
// Shared types and constants for the 12-bit SAR ADC controller.
package adc_sar_pkg;

  localparam int ADC_BITS = 12;
  localparam logic [ADC_BITS-1:0] ADC_MIDSCALE = 12'h800;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    SET,
    CMP,
    DONE
  } sar_state_t;

endpackage

// File: rtl/adc_sar_if.sv
// Host/analog-side signals of the SAR controller; master is the controller itself.
interface adc_sar_if;
  import adc_sar_pkg::*;

  logic                start;
  logic                comp_in;
  logic [ADC_BITS-1:0] data;
  logic                sample;
  logic                comp_en;
  logic                busy;
  logic [ADC_BITS-1:0] result;
  logic                result_valid;

  modport master (
    input  start, comp_in,
    output data, sample, comp_en, busy, result, result_valid
  );

  modport slave (
    output start, comp_in,
    input  data, sample, comp_en, busy, result, result_valid
  );

endinterface

// File: rtl/adc_sar_osr_acc.sv
// Oversampling accumulator: sums conversion codes and presents the truncated average.
module adc_sar_osr_acc
  import adc_sar_pkg::*;
#(
  parameter int OSR_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                add,
  input  logic [ADC_BITS-1:0] code,
  output logic [ADC_BITS-1:0] avg
);

  localparam int ACC_W = ADC_BITS + OSR_LOG2;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;

  // avg already includes the code being added, so the final conversion can
  // be reported in the same edge that resolves its last bit.
  assign sum = acc + ACC_W'(code);
  assign avg = ADC_BITS'(sum >> OSR_LOG2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/adc_sar_controller.sv
// SAR conversion sequencer: sample phase, 12 binary-search trials, registered result.
// Build option ADC_OVERSAMPLE_EN averages 2^OSR_LOG2 conversions per accepted start.
module adc_sar_controller
  import adc_sar_pkg::*;
#(
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
`ifdef ADC_OVERSAMPLE_EN
  ,
  parameter int OSR_LOG2 = 2
`endif
) (
  input logic       clk,
  input logic       rst_n,
  adc_sar_if.master sar
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(ADC_BITS);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] MSB_IDX     = IDX_W'(ADC_BITS - 1);

  sar_state_t          state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [IDX_W-1:0]    bit_idx, bit_idx_d;
  logic [ADC_BITS-1:0] data_q, data_d;
  logic [ADC_BITS-1:0] result_q, result_d;
  logic [ADC_BITS-1:0] code;
  logic [ADC_BITS-1:0] final_code;
  logic                sample_q, comp_en_q, busy_q, result_valid_q;
  logic                last_conv;

  // Running code with the current trial bit resolved by the comparator.
  always_comb begin
    code = data_q;
    if (!sar.comp_in) code[bit_idx] = 1'b0;
  end

`ifdef ADC_OVERSAMPLE_EN
  logic [OSR_LOG2-1:0] conv_cnt, conv_cnt_d;
  logic                acc_clr;
  logic                acc_add;

  assign last_conv = &conv_cnt;
  assign acc_clr   = (state == IDLE) && sar.start;
  assign acc_add   = (state == CMP) && (bit_idx == '0);

  always_comb begin
    conv_cnt_d = conv_cnt;
    if (acc_clr) conv_cnt_d = '0;
    else if (acc_add && !last_conv) conv_cnt_d = conv_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conv_cnt <= '0;
    else        conv_cnt <= conv_cnt_d;
  end

  adc_sar_osr_acc #(.OSR_LOG2(OSR_LOG2)) u_osr_acc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (acc_clr),
    .add  (acc_add),
    .code (code),
    .avg  (final_code)
  );
`else
  assign last_conv  = 1'b1;
  assign final_code = code;
`endif

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_idx_d = bit_idx;
    data_d    = data_q;
    result_d  = result_q;

    case (state)
      IDLE: begin
        data_d = '0;
        if (sar.start) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end
      end
      SAMPLE: begin
        if (cnt == SAMPLE_LAST) begin
          state_d   = SET;
          cnt_d     = '0;
          bit_idx_d = MSB_IDX;
          data_d    = ADC_MIDSCALE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      SET: begin
        if (cnt == SETTLE_LAST) begin
          state_d = CMP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      CMP: begin
        data_d = code;
        if (bit_idx != '0) begin
          data_d[bit_idx - 1'b1] = 1'b1;
          bit_idx_d              = bit_idx - 1'b1;
          state_d                = SET;
        end else if (!last_conv) begin
          // Next sub-conversion starts straight from its own sample phase.
          data_d  = '0;
          state_d = SAMPLE;
        end else begin
          result_d = final_code;
          state_d  = DONE;
        end
      end
      DONE: begin
        data_d  = '0;
        state_d = IDLE;
      end
      default: begin
        data_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state and outputs update with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      data_q         <= '0;
      result_q       <= '0;
      sample_q       <= 1'b0;
      comp_en_q      <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      bit_idx        <= bit_idx_d;
      data_q         <= data_d;
      result_q       <= result_d;
      sample_q       <= (state_d == SAMPLE);
      comp_en_q      <= (state_d == CMP);
      busy_q         <= (state_d != IDLE);
      result_valid_q <= (state_d == DONE);
    end
  end

  assign sar.data         = data_q;
  assign sar.sample       = sample_q;
  assign sar.comp_en      = comp_en_q;
  assign sar.busy         = busy_q;
  assign sar.result       = result_q;
  assign sar.result_valid = result_valid_q;

endmodule

// File: tb/tb_adc_sar_controller.sv
// Self-checking bench: ideal comparator model, directed and random conversions on two configurations.
module tb_adc_sar_controller;
  import adc_sar_pkg::*;

  localparam int SA = 2, TA = 1, SB = 3, TB = 2;
  localparam int NA = SA + ADC_BITS * (TA + 1);
  localparam int NB = SB + ADC_BITS * (TB + 1);
`ifdef ADC_OVERSAMPLE_EN
  localparam int NCONV = 4;
`else
  localparam int NCONV = 1;
`endif
  localparam int WAIT_LIMIT = 1000;

  logic clk = 1'b0;
  logic rst_a_n, rst_b_n;
  int   cyc = 0;
  int   n_total = 0, n_bad = 0;

  adc_sar_if if_a ();
  adc_sar_if if_b ();

  adc_sar_controller #(.SAMPLE_CYCLES(SA), .SETTLE_CYCLES(TA)) u_a (
    .clk  (clk),
    .rst_n(rst_a_n),
    .sar  (if_a)
  );

  adc_sar_controller #(.SAMPLE_CYCLES(SB), .SETTLE_CYCLES(TB)) u_b (
    .clk  (clk),
    .rst_n(rst_b_n),
    .sar  (if_b)
  );

  logic [11:0] vin_a = '0, vin_b = '0;
  logic [11:0] vin_eff_a = '0, vin_eff_b = '0;
  bit          alt_a = 1'b0;
  int          n_cmp_a = 0, n_cmp_b = 0, n_samp_a = 0, n_samp_b = 0;
  int          n_rv_a = 0, n_rv_b = 0, n_idle_a = 0;
  logic [11:0] tr_a[$];
  logic [11:0] tr_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Ideal comparator: keep the trial bit when the input is at or above the trial code.
  assign if_a.comp_in = (vin_eff_a >= if_a.data);
  assign if_b.comp_in = (vin_eff_b >= if_b.data);

  always @(negedge clk) begin
    if (if_a.comp_en) begin
      tr_a.push_back(if_a.data);
      vin_eff_a <= alt_a ? (((n_cmp_a / ADC_BITS) % 2 == 1) ? 12'h103 : 12'h100) : vin_a;
      n_cmp_a   <= n_cmp_a + 1;
    end
    if (if_a.sample)       n_samp_a <= n_samp_a + 1;
    if (if_a.result_valid) n_rv_a   <= n_rv_a + 1;
    if (!if_a.busy)        n_idle_a <= n_idle_a + 1;
  end

  always @(negedge clk) begin
    if (if_b.comp_en) begin
      tr_b.push_back(if_b.data);
      vin_eff_b <= vin_b;
      n_cmp_b   <= n_cmp_b + 1;
    end
    if (if_b.sample)       n_samp_b <= n_samp_b + 1;
    if (if_b.result_valid) n_rv_b   <= n_rv_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One conversion on instance a (sel=0) or b (sel=1); called and returning at posedge+1 in IDLE.
  task automatic run_conv(input bit sel, input logic [11:0] v, input logic [11:0] exp_res,
                          input bit chk_tr, input string tag);
    int          c0, waited, b_cmp, b_samp, b_rv, n_lat, n_s, bad_tr, idx, m;
    logic [11:0] prev_res, exp_tr, got_tr;
    n_lat  = NCONV * (sel ? NB : NA);
    n_s    = NCONV * (sel ? SB : SA);
    b_cmp  = sel ? n_cmp_b : n_cmp_a;
    b_samp = sel ? n_samp_b : n_samp_a;
    b_rv   = sel ? n_rv_b : n_rv_a;
    prev_res = sel ? if_b.result : if_a.result;
    if (sel) begin vin_b = v; if_b.start = 1'b1; end
    else     begin vin_a = v; if_a.start = 1'b1; end
    @(posedge clk); #1;
    c0 = cyc;
    if (sel) if_b.start = 1'b0; else if_a.start = 1'b0;
    check({tag, ".busy_on_start"}, 32'(sel ? if_b.busy : if_a.busy), 1);
    check({tag, ".sample_on_start"}, 32'(sel ? if_b.sample : if_a.sample), 1);
    check({tag, ".result_kept"}, 32'(sel ? if_b.result : if_a.result), 32'(prev_res));
    waited = 0;
    while (!(sel ? if_b.result_valid : if_a.result_valid) && waited < WAIT_LIMIT) begin
      // A start pulse while busy must be ignored.
      if (sel) if_b.start = (waited == 4); else if_a.start = (waited == 4);
      @(posedge clk); #1;
      waited++;
    end
    if (sel) if_b.start = 1'b0; else if_a.start = 1'b0;
    check({tag, ".rv_seen"}, 32'(sel ? if_b.result_valid : if_a.result_valid), 1);
    check({tag, ".latency"}, 32'(cyc - c0), 32'(n_lat));
    check({tag, ".result"}, 32'(sel ? if_b.result : if_a.result), 32'(exp_res));
    if (chk_tr) check({tag, ".done_data"}, 32'(sel ? if_b.data : if_a.data), 32'(exp_res));
    @(posedge clk); #1;
    check({tag, ".rv_single"}, 32'(sel ? if_b.result_valid : if_a.result_valid), 0);
    check({tag, ".idle_busy"}, 32'(sel ? if_b.busy : if_a.busy), 0);
    check({tag, ".idle_data"}, 32'(sel ? if_b.data : if_a.data), 0);
    check({tag, ".rv_count"}, 32'((sel ? n_rv_b : n_rv_a) - b_rv), 1);
    check({tag, ".sample_cycles"}, 32'((sel ? n_samp_b : n_samp_a) - b_samp), 32'(n_s));
    check({tag, ".comp_pulses"}, 32'((sel ? n_cmp_b : n_cmp_a) - b_cmp), 32'(NCONV * ADC_BITS));
    if (chk_tr) begin
      bad_tr = 0;
      for (int c = 0; c < NCONV; c++) begin
        for (int k = ADC_BITS - 1; k >= 0; k--) begin
          idx    = b_cmp + c * ADC_BITS + (ADC_BITS - 1 - k);
          m      = (1 << (k + 1)) - 1;
          exp_tr = 12'((int'(v) & ~m) | (1 << k));
          if (idx >= (sel ? tr_b.size() : tr_a.size())) bad_tr++;
          else begin
            got_tr = sel ? tr_b[idx] : tr_a[idx];
            if (got_tr !== exp_tr) bad_tr++;
          end
        end
      end
      check({tag, ".trial_sequence_errors"}, 32'(bad_tr), 0);
    end
  endtask

  initial begin
    int          waited, c1, b_idle;
    logic [11:0] v;

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.data", 32'(if_a.data), 0);
    check("reset.sample", 32'(if_a.sample), 0);
    check("reset.comp_en", 32'(if_a.comp_en), 0);
    check("reset.busy", 32'(if_a.busy), 0);
    check("reset.result", 32'(if_a.result), 0);
    check("reset.result_valid", 32'(if_a.result_valid), 0);
    check("reset.b_busy", 32'(if_b.busy), 0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    @(posedge clk); #1;
    check("idle.busy", 32'(if_a.busy), 0);

    run_conv(1'b0, 12'hA5A, 12'hA5A, 1'b1, "a5a");
    run_conv(1'b1, 12'h000, 12'h000, 1'b1, "b_zero");
    run_conv(1'b1, 12'hFFF, 12'hFFF, 1'b1, "b_full");
    run_conv(1'b0, 12'hFFF, 12'hFFF, 1'b1, "a_full");
    run_conv(1'b0, 12'h000, 12'h000, 1'b1, "a_zero");
    repeat (3) begin
      v = 12'($urandom_range(0, 4095));
      run_conv(1'b0, v, v, 1'b1, "rand_a");
    end
    repeat (2) begin
      v = 12'($urandom_range(0, 4095));
      run_conv(1'b1, v, v, 1'b1, "rand_b");
    end

    // start held high: back-to-back conversions with a single IDLE cycle between them.
    v      = 12'($urandom_range(1, 4095));
    vin_a  = v;
    if_a.start = 1'b1;
    waited = 0;
    while (!if_a.result_valid && waited < WAIT_LIMIT) begin
      @(posedge clk); #1;
      waited++;
    end
    check("b2b.first_rv", 32'(if_a.result_valid), 1);
    check("b2b.first_result", 32'(if_a.result), 32'(v));
    c1     = cyc;
    b_idle = n_idle_a;
    @(posedge clk); #1;
    check("b2b.gap_busy", 32'(if_a.busy), 0);
    @(posedge clk); #1;
    check("b2b.restart_sample", 32'(if_a.sample), 1);
    waited = 0;
    while (!if_a.result_valid && waited < WAIT_LIMIT) begin
      @(posedge clk); #1;
      waited++;
    end
    if_a.start = 1'b0;
    check("b2b.second_rv", 32'(if_a.result_valid), 1);
    check("b2b.period", 32'(cyc - c1), 32'(NCONV * NA + 2));
    check("b2b.idle_cycles", 32'(n_idle_a - b_idle), 1);
    check("b2b.second_result", 32'(if_a.result), 32'(v));
    @(posedge clk); #1;
    check("b2b.stop_busy", 32'(if_a.busy), 0);
    @(posedge clk); #1;
    check("b2b.not_queued", 32'(if_a.busy), 0);

`ifdef ADC_OVERSAMPLE_EN
    alt_a = 1'b1;
    run_conv(1'b0, 12'h000, 12'h101, 1'b0, "osr_alt");
    alt_a = 1'b0;
`endif

    // Reset asserted during the bit-6 compare cycle.
    v     = 12'($urandom_range(1, 4095));
    vin_a = v;
    if_a.start = 1'b1;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    waited = 0;
    while (!(if_a.comp_en && if_a.data[6:0] == 7'h40) && waited < WAIT_LIMIT) begin
      @(posedge clk); #1;
      waited++;
    end
    check("rst.reached_bit6_cmp", 32'(if_a.comp_en), 1);
    rst_a_n = 1'b0;
    #1;
    check("rst.data", 32'(if_a.data), 0);
    check("rst.sample", 32'(if_a.sample), 0);
    check("rst.comp_en", 32'(if_a.comp_en), 0);
    check("rst.busy", 32'(if_a.busy), 0);
    check("rst.result", 32'(if_a.result), 0);
    check("rst.result_valid", 32'(if_a.result_valid), 0);
    @(posedge clk); #1;
    rst_a_n = 1'b1;
    check("rst.held_busy", 32'(if_a.busy), 0);
    @(posedge clk); #1;
    v = 12'($urandom_range(0, 4095));
    run_conv(1'b0, v, v, 1'b1, "after_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
